// File: rtl/step_pulse_gen_multi.sv
// Step-strobe generator (exact phase accumulator) plus the 1 Hz / 0.5 Hz tracker timebase.
// Define HYBRID_MODE_EN to build the mode-11 hybrid rate sequencer; otherwise mode 11 selects rate 0.
module step_pulse_gen_multi #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int RATE_W    = 8,
  parameter int RATE_WALK = 32,
  parameter int RATE_JOG  = 64,
  parameter int RATE_RUN  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              pulse,
  output logic              clk_1hz,
  output logic              clk_halfhz,
  output logic              tick_1hz,
  output logic [RATE_W-1:0] cur_rate
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam int ACC_W = CNT_W + RATE_W;
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] SEC_HALF = CNT_W'(CLK_HZ / 2);
  localparam logic [ACC_W-1:0] ACC_MOD  = ACC_W'(CLK_HZ);

  logic [CNT_W-1:0]  r_sec_cnt;
  logic              r_tick_1hz;
  logic              r_clk_1hz;
  logic              r_clk_halfhz;
  logic [ACC_W-1:0]  r_acc;
  logic              r_pulse;
  logic [RATE_W-1:0] r_cur_rate;
  logic [RATE_W-1:0] w_rate;
  logic [RATE_W-1:0] w_hyb_rate;
  logic [ACC_W-1:0]  w_acc_sum;
  logic              w_sec_wrap;

  assign w_sec_wrap = (r_sec_cnt == SEC_LAST);

  // Free-running timebase: independent of start and mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_cnt    <= '0;
      r_tick_1hz   <= 1'b0;
      r_clk_1hz    <= 1'b0;
      r_clk_halfhz <= 1'b0;
    end else begin
      r_sec_cnt  <= w_sec_wrap ? '0 : r_sec_cnt + 1'b1;
      r_tick_1hz <= w_sec_wrap;
      r_clk_1hz  <= (r_sec_cnt < SEC_HALF);
      if (w_sec_wrap)
        r_clk_halfhz <= ~r_clk_halfhz;
    end
  end

`ifdef HYBRID_MODE_EN
  logic [CNT_W-1:0] r_hyb_cnt;
  logic [3:0]       r_hyb_idx;
  logic             w_hyb_active;

  assign w_hyb_active = start && (mode == 2'b11);

  // Hybrid seconds are counted from mode entry, so both counters idle at 0 outside mode 11.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hyb_cnt <= '0;
      r_hyb_idx <= '0;
    end else if (!w_hyb_active) begin
      r_hyb_cnt <= '0;
      r_hyb_idx <= '0;
    end else if (r_hyb_cnt == SEC_LAST) begin
      r_hyb_cnt <= '0;
      if (r_hyb_idx != 4'd9)
        r_hyb_idx <= r_hyb_idx + 4'd1;
    end else begin
      r_hyb_cnt <= r_hyb_cnt + 1'b1;
    end
  end

  always_comb begin
    w_hyb_rate = RATE_W'(69);
    case (r_hyb_idx)
      4'd0:    w_hyb_rate = RATE_W'(20);
      4'd1:    w_hyb_rate = RATE_W'(33);
      4'd2:    w_hyb_rate = RATE_W'(66);
      4'd3:    w_hyb_rate = RATE_W'(27);
      4'd4:    w_hyb_rate = RATE_W'(70);
      4'd5:    w_hyb_rate = RATE_W'(30);
      4'd6:    w_hyb_rate = RATE_W'(19);
      4'd7:    w_hyb_rate = RATE_W'(30);
      4'd8:    w_hyb_rate = RATE_W'(33);
      default: w_hyb_rate = RATE_W'(69);
    endcase
  end
`else
  assign w_hyb_rate = '0;
`endif

  always_comb begin
    w_rate = '0;
    if (start) begin
      case (mode)
        2'b00:   w_rate = RATE_W'(RATE_WALK);
        2'b01:   w_rate = RATE_W'(RATE_JOG);
        2'b10:   w_rate = RATE_W'(RATE_RUN);
        default: w_rate = w_hyb_rate;
      endcase
    end
  end

  assign w_acc_sum = r_acc + {{CNT_W{1'b0}}, w_rate};

  // Phase accumulator keeps its residue across rate changes; only start=0 rewinds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_pulse    <= 1'b0;
      r_cur_rate <= '0;
    end else begin
      r_cur_rate <= w_rate;
      if (!start) begin
        r_acc   <= '0;
        r_pulse <= 1'b0;
      end else if (w_acc_sum >= ACC_MOD) begin
        r_acc   <= w_acc_sum - ACC_MOD;
        r_pulse <= 1'b1;
      end else begin
        r_acc   <= w_acc_sum;
        r_pulse <= 1'b0;
      end
    end
  end

  assign pulse      = r_pulse;
  assign clk_1hz    = r_clk_1hz;
  assign clk_halfhz = r_clk_halfhz;
  assign tick_1hz   = r_tick_1hz;
  assign cur_rate   = r_cur_rate;

endmodule
